// File: rtl/step_sequencer.sv
// step_sequencer: plays a STEPS-entry {note,gate} pattern loop into the synth's trig/osc_count.
// Registered outputs, step 0 one cycle after run is seen; no backpressure. `SEQ_LOOP_LEN_EN adds loop_len.
module step_sequencer #(
    parameter int STEPS  = 16,
    parameter int OSC_W  = 8,
    parameter int TICK_W = 24,
    localparam int AW    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [TICK_W-1:0] step_ticks,
    input  logic [TICK_W-1:0] gate_ticks,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [OSC_W-1:0]  wr_note,
    input  logic              wr_gate,
`ifdef SEQ_LOOP_LEN_EN
    input  logic [AW-1:0]     loop_len,
`endif
    output logic              trig,
    output logic [OSC_W-1:0]  osc_count,
    output logic [AW-1:0]     step,
    output logic              step_pulse
);

    typedef enum logic [1:0] {IDLE, PLAY_GATE, PLAY_REST} state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [AW-1:0]      step_q, step_d;
    logic [OSC_W-1:0]   osc_q, osc_d;
    logic               trig_q, trig_d;
    logic               pulse_q, pulse_d;
    logic               start_q, start_d;

    logic [OSC_W-1:0]   note_q [STEPS];
    logic [STEPS-1:0]   gate_q;

    logic [TICK_W-1:0]  eff_step, eff_last, eff_gate, tick_inc;
    logic               at_end, wrap;
    logic [AW-1:0]      next_step;

    always_comb begin
        eff_step = (step_ticks < TICK_W'(2)) ? TICK_W'(2) : step_ticks;
        eff_last = eff_step - TICK_W'(1);
        eff_gate = (gate_ticks > eff_last) ? eff_last : gate_ticks;
    end

    assign tick_inc = tick_q + TICK_W'(1);
    // start_q forces an immediate load of step 0 on the cycle after run is seen
    assign at_end   = start_q || (tick_q >= eff_last);

`ifdef SEQ_LOOP_LEN_EN
    assign wrap = (step_q >= loop_len);
`else
    assign wrap = (step_q == AW'(STEPS - 1));
`endif
    assign next_step = (start_q || wrap) ? '0 : step_q + AW'(1);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        step_d  = step_q;
        osc_d   = osc_q;
        pulse_d = 1'b0;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = PLAY_REST;
                    start_d = 1'b1;
                    tick_d  = '0;
                end
            end
            default: begin
                if (!run) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else if (at_end && state_q == PLAY_GATE) begin
                    // gate still high at a shrunk boundary: drop trig first so the next step retriggers
                    state_d = PLAY_REST;
                end else if (at_end) begin
                    step_d  = next_step;
                    osc_d   = note_q[next_step];
                    pulse_d = 1'b1;
                    tick_d  = '0;
                    state_d = (gate_q[next_step] && eff_gate != '0) ? PLAY_GATE : PLAY_REST;
                end else begin
                    tick_d = tick_inc;
                    if (state_q == PLAY_GATE && tick_inc >= eff_gate) begin
                        state_d = PLAY_REST;
                    end
                end
            end
        endcase
        trig_d = (state_d == PLAY_GATE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            step_q  <= '0;
            osc_q   <= '0;
            trig_q  <= 1'b0;
            pulse_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            osc_q   <= osc_d;
            trig_q  <= trig_d;
            pulse_q <= pulse_d;
            start_q <= start_d;
        end
    end

    // a load on the same edge as a write sees the old entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STEPS; i++) begin
                note_q[i] <= '0;
            end
            gate_q <= '0;
        end else if (wr_en) begin
            note_q[wr_addr] <= wr_note;
            gate_q[wr_addr] <= wr_gate;
        end
    end

    assign trig       = trig_q;
    assign osc_count  = osc_q;
    assign step       = step_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: table-driven step timing, hand-written corner sequences, randomized model check.
module tb_step_sequencer;

    localparam int STEPS = 16;

    logic        clk, rst, run, wr_en, wr_gate;
    logic [23:0] step_ticks, gate_ticks;
    logic [3:0]  wr_addr, step, loop_len;
    logic [7:0]  wr_note, osc_count;
    logic        trig, step_pulse;

    int vectors, miscompares;

    step_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .step_ticks(step_ticks), .gate_ticks(gate_ticks),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_gate(wr_gate),
`ifdef SEQ_LOOP_LEN_EN
        .loop_len(loop_len),
`endif
        .trig(trig), .osc_count(osc_count), .step(step), .step_pulse(step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st;
        int gt;
        int period;
        int high;
    } tvec_t;

    tvec_t tv [8];
    int    mnote [STEPS];
    bit    mgate [STEPS];
    int    rest_hi [4];
    int    ll_exp [5];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input int n, input bit g);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_note = 8'(n);
        wr_gate = g;
        cyc();
        wr_en   = 1'b0;
    endtask

    // from a step_pulse cycle: cycles until the next pulse and trig-high cycles within the step
    task automatic measure(output int n, output int hi, output bit prev);
        n = 0; hi = 0; prev = 1'b0;
        do begin
            hi   += int'(trig);
            prev  = trig;
            n++;
            cyc();
        end while (!step_pulse && n < 40);
    endtask

    task automatic wait_step(input int s, input int bound);
        int found;
        found = 0;
        for (int i = 0; i < bound; i++) begin
            cyc();
            if (step_pulse && step == 4'(s)) begin
                found = 1;
                break;
            end
        end
        chk("wait_step_timeout", found, 1);
    endtask

    initial begin
        int n, hi, e, g, st, gt, kmax, s, t, slast, cnt;
        bit prev;
        vectors = 0; miscompares = 0;
        rst = 1'b0; run = 1'b0; wr_en = 1'b0; wr_gate = 1'b0;
        wr_addr = '0; wr_note = '0; step_ticks = '0; gate_ticks = '0;
        loop_len = 4'(STEPS - 1);

        tv[0] = '{8, 3, 8, 3};
        tv[1] = '{8, 20, 8, 7};
        tv[2] = '{0, 0, 2, 0};
        tv[3] = '{1, 5, 2, 1};
        tv[4] = '{2, 1, 2, 1};
        tv[5] = '{5, 0, 5, 0};
        tv[6] = '{3, 2, 3, 2};
        tv[7] = '{6, 6, 6, 5};
        rest_hi = '{7, 7, 0, 7};
        ll_exp  = '{0, 1, 2, 3, 0};

        // reset state
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_trig", trig, 0);
        chk("rst_osc", osc_count, 0);
        chk("rst_step", step, 0);
        chk("rst_pulse", step_pulse, 0);

        // basic loop
        for (int i = 0; i < STEPS; i++) wr(i, 10 + i, 1'b1);
        step_ticks = 8; gate_ticks = 3; run = 1'b1;
        cyc();
        chk("start_lat_pulse", step_pulse, 0);
        chk("start_lat_trig", trig, 0);
        cyc();
        chk("start_pulse", step_pulse, 1);
        chk("start_step", step, 0);
        chk("start_osc", osc_count, 10);
        chk("start_trig", trig, 1);
        for (int k = 1; k <= STEPS; k++) begin
            measure(n, hi, prev);
            chk("basic_period", n, 8);
            chk("basic_trig_high", hi, 3);
            chk("basic_osc", osc_count, 10 + (k % STEPS));
        end

        // reset mid-playback, release with run low
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("midrst_trig", trig, 0);
        chk("midrst_osc", osc_count, 0);
        chk("midrst_step", step, 0);
        chk("midrst_pulse", step_pulse, 0);
        run = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            cnt += int'(step_pulse) + int'(trig);
        end
        chk("idle_no_activity", cnt, 0);

        // table-driven step timing
        for (int i = 0; i < STEPS; i++) wr(i, i, 1'b1);
        for (int v = 0; v < 8; v++) begin
            step_ticks = 24'(tv[v].st); gate_ticks = 24'(tv[v].gt); run = 1'b1;
            cyc(); cyc();
            chk("tbl_first_pulse", step_pulse, 1);
            measure(n, hi, prev);
            chk("tbl_period", n, tv[v].period);
            chk("tbl_trig_high", hi, tv[v].high);
            run = 1'b0;
            cyc(); cyc();
        end

        // rests and retrigger
        for (int i = 0; i < STEPS; i++) wr(i, 40 + i, (i % 4) != 2);
        step_ticks = 8; gate_ticks = 20; run = 1'b1;
        cyc(); cyc();
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("retrig_edge", {30'd0, prev, trig}, (i == 2) ? 0 : 1);
            measure(n, hi, prev);
            chk("rest_period", n, 8);
            chk("rest_trig_high", hi, rest_hi[i]);
        end

        // stop during step 5 and restart
        wait_step(5, 40);
        cyc(); cyc();
        chk("stop_pre_trig", trig, 1);
        run = 1'b0;
        cyc();
        chk("stop_trig", trig, 0);
        chk("stop_step", step, 5);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            cnt += int'(step_pulse) + int'(trig);
        end
        chk("stop_quiet", cnt, 0);
        chk("stop_hold_step", step, 5);
        chk("stop_hold_osc", osc_count, 45);
        run = 1'b1;
        cyc();
        chk("restart_lat_step", step, 5);
        cyc();
        chk("restart_step", step, 0);
        chk("restart_pulse", step_pulse, 1);
        chk("restart_osc", osc_count, 40);

        // write to the step currently playing
        wait_step(1, 20);
        chk("live_osc_before", osc_count, 41);
        wr(1, 99, 1'b1);
        chk("live_osc_after_wr", osc_count, 41);
        wait_step(1, 200);
        chk("live_osc_next_pass", osc_count, 99);

        // shrinking step_ticks below the running tick ends the step next cycle
        run = 1'b0;
        cyc();
        step_ticks = 10; gate_ticks = 0; run = 1'b1;
        cyc(); cyc();
        repeat (6) cyc();
        chk("shrink_pre_pulse", step_pulse, 0);
        step_ticks = 4;
        cyc();
        chk("shrink_pulse", step_pulse, 1);
        chk("shrink_step", step, 1);
        run = 1'b0;
        cyc();

`ifdef SEQ_LOOP_LEN_EN
        step_ticks = 2; loop_len = 3; run = 1'b1;
        cyc();
        for (int p = 0; p < 5; p++) begin
            cnt = 0;
            for (int i = 0; i < 10 && cnt == 0; i++) begin
                cyc();
                if (step_pulse) cnt = 1;
            end
            chk("looplen_pulse", cnt, 1);
            chk("looplen_step", step, ll_exp[p]);
        end
        run = 1'b0;
        cyc();
        loop_len = 4'(STEPS - 1);
`endif

        // randomized rounds against an arithmetic model of the playback
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < STEPS; i++) begin
                mnote[i] = $urandom_range(0, 255);
                mgate[i] = 1'($urandom_range(0, 1));
                wr(i, mnote[i], mgate[i]);
            end
            st = $urandom_range(0, 12);
            gt = $urandom_range(0, 15);
            e  = (st < 2) ? 2 : st;
            g  = (gt > e - 1) ? e - 1 : gt;
            step_ticks = 24'(st); gate_ticks = 24'(gt); run = 1'b1;
            cyc();
            chk("rnd_start_pulse", step_pulse, 0);
            kmax  = $urandom_range(20, 90);
            slast = 0;
            for (int k = 1; k <= kmax; k++) begin
                cyc();
                t = (k - 1) % e;
                s = ((k - 1) / e) % STEPS;
                slast = s;
                chk("rnd_trig", trig, (mgate[s] && t < g) ? 1 : 0);
                chk("rnd_osc", osc_count, mnote[s]);
                chk("rnd_step", step, s);
                chk("rnd_pulse", step_pulse, (t == 0) ? 1 : 0);
            end
            run = 1'b0;
            cyc();
            chk("rnd_stop_trig", trig, 0);
            chk("rnd_stop_step", step, slast);
            chk("rnd_stop_pulse", step_pulse, 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
